// File: rtl/alu_op_cell_pkg.sv
// Shared op-code and state encodings for the ALU op cell family.
// The optional flag outputs are enabled by defining ALU_OP_CELL_FLAGS_EN.
package alu_op_cell_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  // Reserved codes run as ADD, so only the three bitwise ops are logical.
  function automatic logic op_is_logical(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/alu_op_cell_datapath.sv
// Combinational acc OP d; also emits carry/borrow and signed overflow
// when ALU_OP_CELL_FLAGS_EN is defined.
module alu_op_cell_datapath
  import alu_op_cell_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
`ifdef ALU_OP_CELL_FLAGS_EN
  output logic             carry,
  output logic             overflow,
`endif
  output logic [WIDTH-1:0] res
);

`ifdef ALU_OP_CELL_FLAGS_EN
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] dif_ext;

  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign dif_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    res      = sum_ext[WIDTH-1:0];
    carry    = sum_ext[WIDTH];
    overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
    case (op)
      OP_SUB: begin
        res      = dif_ext[WIDTH-1:0];
        carry    = dif_ext[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      default: ;
    endcase
  end
`else
  always_comb begin
    case (op)
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: res = a + b;
    endcase
  end
`endif

endmodule

// File: rtl/alu_op_cell_multi.sv
// Accumulating ALU op cell: folds up to MAX_OPERANDS operands with one op.
// Optional o_carry/o_overflow/o_zero outputs under ALU_OP_CELL_FLAGS_EN.
module alu_op_cell_multi
  import alu_op_cell_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int MAX_OPERANDS = 4,
  localparam int CW          = $clog2(MAX_OPERANDS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [2:0]       i_op,
  input  logic             i_result_ready,
  output logic             o_result_valid,
  output logic [WIDTH-1:0] o_result,
`ifdef ALU_OP_CELL_FLAGS_EN
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero,
`endif
  output logic [CW-1:0]    o_count
);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] dp_res;
  logic             accept, pop, fresh;

  assign o_data_ready   = (count_q != CW'(MAX_OPERANDS));
  assign o_result_valid = (state_q == ST_ACCUM);
  assign o_result       = acc_q;
  assign o_count        = count_q;

  assign accept = i_data_valid && o_data_ready;
  assign pop    = o_result_valid && i_result_ready;
  // A pop frees the cell, so a same-cycle operand begins a new fold.
  assign fresh  = (state_q == ST_EMPTY) || pop;

`ifdef ALU_OP_CELL_FLAGS_EN
  logic dp_carry, dp_ovf;
  logic carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;

  alu_op_cell_datapath #(.WIDTH(WIDTH)) u_dp (
    .a        (acc_q),
    .b        (i_data),
    .op       (op_q),
    .carry    (dp_carry),
    .overflow (dp_ovf),
    .res      (dp_res)
  );
`else
  alu_op_cell_datapath #(.WIDTH(WIDTH)) u_dp (
    .a   (acc_q),
    .b   (i_data),
    .op  (op_q),
    .res (dp_res)
  );
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    op_d    = op_q;
    if (accept && fresh) begin
      state_d = ST_ACCUM;
      acc_d   = i_data;
      count_d = CW'(1);
      op_d    = i_op;
    end else if (accept) begin
      acc_d   = dp_res;
      count_d = count_q + CW'(1);
    end else if (pop) begin
      state_d = ST_EMPTY;
      acc_d   = '0;
      count_d = '0;
    end
  end

`ifdef ALU_OP_CELL_FLAGS_EN
  always_comb begin
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (accept && fresh) begin
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      zero_d  = (i_data == '0);
    end else if (accept) begin
      if (!op_is_logical(op_q)) begin
        carry_d = carry_q | dp_carry;
        ovf_d   = ovf_q | dp_ovf;
      end
      zero_d = (dp_res == '0);
    end else if (pop) begin
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      zero_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign o_carry    = carry_q;
  assign o_overflow = ovf_q;
  assign o_zero     = zero_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      acc_q   <= '0;
      count_q <= '0;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_alu_op_cell_multi.sv
// Self-checking bench for alu_op_cell_multi: directed vector table,
// hand sequences for reset, then random traffic against a queue model.
module tb_alu_op_cell_multi;
  localparam int W  = 32;
  localparam int MX = 4;
  localparam int CW = $clog2(MX + 1);

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_data_valid = 1'b0;
  logic          o_data_ready;
  logic [W-1:0]  i_data = '0;
  logic [2:0]    i_op = 3'd0;
  logic          i_result_ready = 1'b0;
  logic          o_result_valid;
  logic [W-1:0]  o_result;
  logic [CW-1:0] o_count;
`ifdef ALU_OP_CELL_FLAGS_EN
  logic          o_carry, o_overflow, o_zero;
`endif

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  alu_op_cell_multi #(.WIDTH(W), .MAX_OPERANDS(MX)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_data_valid   (i_data_valid),
    .o_data_ready   (o_data_ready),
    .i_data         (i_data),
    .i_op           (i_op),
    .i_result_ready (i_result_ready),
    .o_result_valid (o_result_valid),
    .o_result       (o_result),
`ifdef ALU_OP_CELL_FLAGS_EN
    .o_carry        (o_carry),
    .o_overflow     (o_overflow),
    .o_zero         (o_zero),
`endif
    .o_count        (o_count)
  );

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic [2:0]   op;
    logic         rr;
    logic [W-1:0] e_res;
    int           e_cnt;
    logic         e_vld;
    logic         e_rdy;
  } vec_t;

  vec_t vt[$];

  // Reference model: the accepted operands themselves, folded on demand.
  logic [W-1:0] mq[$];
  logic [2:0]   m_op;

  function automatic logic [W-1:0] fold(input logic [W-1:0] q[$], input logic [2:0] op);
    logic [W-1:0] r;
    if (q.size() == 0) return '0;
    r = q[0];
    for (int i = 1; i < q.size(); i++) begin
      case (op)
        3'd1:    r = r - q[i];
        3'd2:    r = r & q[i];
        3'd3:    r = r | q[i];
        3'd4:    r = r ^ q[i];
        default: r = r + q[i];
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_v(input logic v, input logic [W-1:0] d, input logic [2:0] op, input logic rr,
                       input logic [W-1:0] er, input int ec, input logic ev, input logic erdy);
    vec_t x;
    x.v = v; x.d = d; x.op = op; x.rr = rr;
    x.e_res = er; x.e_cnt = ec; x.e_vld = ev; x.e_rdy = erdy;
    vt.push_back(x);
  endtask

  // Drive one cycle, advance the model with pre-edge handshake, sample #1 after the edge.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic [2:0] op, input logic rr);
    logic acc, pp;
    i_data_valid = v; i_data = d; i_op = op; i_result_ready = rr;
    acc = v && (mq.size() != MX);
    pp  = rr && (mq.size() != 0);
    @(posedge i_clk);
    #1;
    if (pp) mq.delete();
    if (acc) begin
      if (mq.size() == 0) m_op = op;
      mq.push_back(d);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " result"}, o_result, fold(mq, m_op));
    chk({tag, " valid"},  W'(o_result_valid), W'(mq.size() != 0));
    chk({tag, " count"},  W'(o_count), W'(mq.size()));
    chk({tag, " ready"},  W'(o_data_ready), W'(mq.size() != MX));
  endtask

  initial begin
    // ADD 0x1B + 0x0E, pop
    add_v(1, 32'h1B, 3'd0, 0, 32'h1B, 1, 1, 1);
    add_v(1, 32'h0E, 3'd2, 0, 32'h29, 2, 1, 1);
    add_v(0, 32'h0,  3'd0, 1, 32'h0,  0, 0, 1);
    // AND stream; op change on operand 2 ignored
    add_v(1, 32'h3F, 3'd2, 0, 32'h3F, 1, 1, 1);
    add_v(1, 32'h38, 3'd3, 0, 32'h38, 2, 1, 1);
    add_v(1, 32'h18, 3'd0, 0, 32'h18, 3, 1, 1);
    add_v(0, 32'h0,  3'd0, 1, 32'h0,  0, 0, 1);
    // OR stream
    add_v(1, 32'h3F, 3'd3, 0, 32'h3F, 1, 1, 1);
    add_v(1, 32'h38, 3'd3, 0, 32'h3F, 2, 1, 1);
    add_v(1, 32'h18, 3'd3, 0, 32'h3F, 3, 1, 1);
    add_v(0, 32'h0,  3'd0, 1, 32'h0,  0, 0, 1);
    // XOR stream
    add_v(1, 32'h3F, 3'd4, 0, 32'h3F, 1, 1, 1);
    add_v(1, 32'h38, 3'd4, 0, 32'h07, 2, 1, 1);
    add_v(1, 32'h18, 3'd4, 0, 32'h1F, 3, 1, 1);
    add_v(0, 32'h0,  3'd0, 1, 32'h0,  0, 0, 1);
    // Fill, back-pressure, pop while offering, then 5th accepted
    add_v(1, 32'h1, 3'd0, 0, 32'h1, 1, 1, 1);
    add_v(1, 32'h1, 3'd0, 0, 32'h2, 2, 1, 1);
    add_v(1, 32'h1, 3'd0, 0, 32'h3, 3, 1, 1);
    add_v(1, 32'h1, 3'd0, 0, 32'h4, 4, 1, 0);
    add_v(1, 32'h1, 3'd0, 0, 32'h4, 4, 1, 0);
    add_v(1, 32'h1, 3'd0, 1, 32'h0, 0, 0, 1);
    add_v(1, 32'h1, 3'd0, 0, 32'h1, 1, 1, 1);
    add_v(0, 32'h0, 3'd0, 1, 32'h0, 0, 0, 1);
    // ADD wrap, SUB borrow
    add_v(1, 32'hFFFF_FFFF, 3'd0, 0, 32'hFFFF_FFFF, 1, 1, 1);
    add_v(1, 32'h2,         3'd0, 0, 32'h1,         2, 1, 1);
    add_v(0, 32'h0,         3'd0, 1, 32'h0,         0, 0, 1);
    add_v(1, 32'h0,         3'd1, 0, 32'h0,         1, 1, 1);
    add_v(1, 32'h1,         3'd1, 0, 32'hFFFF_FFFF, 2, 1, 1);
    add_v(0, 32'h0,         3'd0, 1, 32'h0,         0, 0, 1);
    // Pop and new operand in the same cycle
    add_v(1, 32'h1B, 3'd0, 0, 32'h1B, 1, 1, 1);
    add_v(1, 32'h0E, 3'd0, 0, 32'h29, 2, 1, 1);
    add_v(1, 32'h05, 3'd0, 1, 32'h05, 1, 1, 1);
    add_v(0, 32'h0,  3'd0, 1, 32'h0,  0, 0, 1);
    // Reserved op runs as ADD
    add_v(1, 32'h7, 3'd5, 0, 32'h7, 1, 1, 1);
    add_v(1, 32'h3, 3'd1, 0, 32'hA, 2, 1, 1);
    add_v(0, 32'h0, 3'd0, 1, 32'h0, 0, 0, 1);

    m_op = 3'd0;
    #2;
    chk("reset valid",  W'(o_result_valid), '0);
    chk("reset result", o_result, '0);
    chk("reset count",  W'(o_count), '0);
    chk("reset ready",  W'(o_data_ready), W'(1));
    @(negedge i_clk);
    i_rst_n = 1'b1;

    foreach (vt[k]) begin
      cyc(vt[k].v, vt[k].d, vt[k].op, vt[k].rr);
      chk($sformatf("vec%0d result", k), o_result, vt[k].e_res);
      chk($sformatf("vec%0d count", k),  W'(o_count), W'(vt[k].e_cnt));
      chk($sformatf("vec%0d valid", k),  W'(o_result_valid), W'(vt[k].e_vld));
      chk($sformatf("vec%0d ready", k),  W'(o_data_ready), W'(vt[k].e_rdy));
    end

    // Async reset mid-accumulation, between edges
    cyc(1, 32'h10, 3'd0, 0);
    cyc(1, 32'h20, 3'd0, 0);
    chk("pre-rst result", o_result, 32'h30);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async rst valid",  W'(o_result_valid), '0);
    chk("async rst count",  W'(o_count), '0);
    chk("async rst result", o_result, '0);
    chk("async rst ready",  W'(o_data_ready), W'(1));
    mq.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc(1, 32'h3, 3'd1, 0);
    cyc(1, 32'h4, 3'd1, 0);
    chk("post-rst result", o_result, 32'hFFFF_FFFF);
    chk("post-rst count",  W'(o_count), W'(2));
    cyc(0, 32'h0, 3'd0, 1);
    chk("post-rst pop", W'(o_result_valid), '0);

    // Random traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      logic         v, rr;
      logic [W-1:0] d;
      v  = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) == 0);
      d  = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 15));
      cyc(v, d, 3'($urandom_range(0, 7)), rr);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
